// File: rtl/serializer_pkg.sv
// Shared definitions for the PISO serializer: state encoding, counter width, parity helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package serializer_pkg;

    // Default frame width and the bit-counter width it implies.
    localparam int SER_WIDTH = 8;
    localparam int SER_CNT_W = $clog2(SER_WIDTH);

    // Transmit FSM encoding; kept as plain constants for legacy tools.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    // Even parity over up to 32 data bits; callers zero-extend narrower words.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Loadable, clearable modulo-MOD counter with terminal-count flag.
// Latency: count updates on the clock edge after clr/ld/inc.
// Backpressure: none; holds its value when no control is asserted.
//
// Ports: CLK, RST_N (async active-low), clr (to zero, highest priority),
//        ld/ld_val (parallel load), inc (advance, wraps to 0 after MOD-1),
//        cnt (current value), tc (cnt == MOD-1).
module bit_counter #(
    parameter int MOD = 8,
    parameter int CW  = $clog2(MOD)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          clr,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == CW'(MOD - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: WIDTH-bit word shifted out LSB first with frame strobes.
// Latency: bit 0 is on SER_OUT the cycle after the accepting edge; one bit per cycle after that.
// Backpressure: LOAD_READY only in IDLE and in a frame's final bit cycle, giving gapless back-to-back frames.
//
// Ports: CLK, RST_N (async active-low, aborts any frame), LOAD_VALID/LOAD_READY/DATA_IN
//        (load handshake), SER_OUT/SER_VALID (serial bit), FRAME_START (bit 0 pulse),
//        DONE (final bit pulse).
// Option: define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits;
//         DONE and LOAD_READY then move to that parity cycle.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic             SER_OUT,
    output logic             SER_VALID,
    output logic             FRAME_START,
    output logic             DONE
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             cnt_clr, cnt_inc;
    logic             accept;
    logic             ser_out_d, done_d;
`ifdef SERIALIZER_PARITY_EN
    logic             par_q;
`endif

    bit_counter #(
        .MOD (WIDTH),
        .CW  (CNT_W)
    ) u_cnt (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clr    (cnt_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (cnt_inc),
        .cnt    (cnt),
        .tc     (cnt_tc)
    );

    // LOAD_READY is registered, so it already reflects the current cycle.
    assign accept = LOAD_VALID && LOAD_READY;

    // Next-state logic. All outputs are registered from the next-cycle view
    // so they line up with the state/count that the next cycle will hold.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = DATA_IN;
                    cnt_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!cnt_tc) begin
                    shreg_d = shreg_q >> 1;
                    cnt_inc = 1'b1;
`ifndef SERIALIZER_PARITY_EN
                    // Next cycle carries the last data bit.
                    done_d  = (cnt == CNT_W'(WIDTH - 2));
`endif
`ifdef SERIALIZER_PARITY_EN
                end else begin
                    // Counter parks at WIDTH-1 through the parity cycle.
                    state_d = ST_PARITY;
                    done_d  = 1'b1;
                end
`else
                end else if (accept) begin
                    shreg_d = DATA_IN;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    cnt_clr = 1'b1;
                end
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = DATA_IN;
                end else begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                end
                cnt_clr = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_clr = 1'b1;
            end
        endcase

        ser_out_d = 1'b0;
        if (state_d == ST_SHIFT) begin
            ser_out_d = shreg_d[0];
        end
`ifdef SERIALIZER_PARITY_EN
        if (state_d == ST_PARITY) begin
            ser_out_d = par_q;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            SER_OUT     <= 1'b0;
            SER_VALID   <= 1'b0;
            FRAME_START <= 1'b0;
            DONE        <= 1'b0;
            LOAD_READY  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            SER_OUT     <= ser_out_d;
            SER_VALID   <= (state_d != ST_IDLE);
            // Every accept starts a frame at bit 0 on the next cycle.
            FRAME_START <= accept;
            DONE        <= done_d;
            LOAD_READY  <= (state_d == ST_IDLE) || done_d;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    // Parity captured with the word so later DATA_IN changes cannot disturb it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= even_parity(32'(DATA_IN));
        end
    end
`endif

endmodule
